// File: rtl/regfile_bist_pkg.sv
// Shared constants for the register-file March C- BIST controller:
// FSM state codes, march element codes, and the per-element op table.
package regfile_bist_pkg;

    // FSM state codes
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // March C- element codes
    localparam logic [2:0] M0 = 3'd0;
    localparam logic [2:0] M1 = 3'd1;
    localparam logic [2:0] M2 = 3'd2;
    localparam logic [2:0] M3 = 3'd3;
    localparam logic [2:0] M4 = 3'd4;
    localparam logic [2:0] M5 = 3'd5;

    // Op encoding: bit 1 = read (1) / write (0), bit 0 = data pattern (D0/D1)
    localparam logic [1:0] OP_W0 = 2'b00;
    localparam logic [1:0] OP_W1 = 2'b01;
    localparam logic [1:0] OP_R0 = 2'b10;
    localparam logic [1:0] OP_R1 = 2'b11;

    // Number of ops each element performs per address
    function automatic logic [1:0] elem_op_count(input logic [2:0] elem);
        case (elem)
            M1, M2, M3, M4: elem_op_count = 2'd2;
            default:        elem_op_count = 2'd1;
        endcase
    endfunction

    // Address direction of each element: 1 = ascending, 0 = descending
    function automatic logic elem_dir_up(input logic [2:0] elem);
        case (elem)
            M0, M1, M2: elem_dir_up = 1'b1;
            default:    elem_dir_up = 1'b0;
        endcase
    endfunction

    // Op issued by a given element at a given position within the element
    function automatic logic [1:0] elem_op(input logic [2:0] elem, input logic op_idx);
        case (elem)
            M0:      elem_op = OP_W0;
            M1:      elem_op = op_idx ? OP_W1 : OP_R0;
            M2:      elem_op = op_idx ? OP_W0 : OP_R1;
            M3:      elem_op = op_idx ? OP_W1 : OP_R0;
            M4:      elem_op = op_idx ? OP_W0 : OP_R1;
            M5:      elem_op = OP_R0;
            default: elem_op = OP_W0;
        endcase
    endfunction

endpackage

// File: rtl/regfile_bist_addr_gen.sv
// Up/down test-address counter with parallel load and a flag that marks
// the final address of the current sweep direction.
module regfile_bist_addr_gen #(
    parameter int                    ADDR_WIDTH = 5,
    parameter logic [ADDR_WIDTH-1:0] MAX_ADDR   = ADDR_WIDTH'((2 ** (ADDR_WIDTH - 1)) - 2)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_val,
    input  logic                  step,
    input  logic                  up,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    // Load takes priority over stepping; step moves one address in the sweep direction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (load) begin
            addr <= load_val;
        end else if (step) begin
            addr <= up ? (addr + ADDR_WIDTH'(1)) : (addr - ADDR_WIDTH'(1));
        end
    end

    // Final address is the top of the range going up, zero going down
    always_comb begin
        last = up ? (addr == MAX_ADDR) : (addr == '0);
    end

endmodule

// File: rtl/regfile_march_bist_ctrl.sv
// March C- BIST controller for the register-file test port. Sweeps the
// writable addresses 0..N-1, issuing one op per cycle, checks read data one
// cycle later and records the first failing address and march element.
module regfile_march_bist_ctrl
    import regfile_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  fail_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [2:0]            fail_elem_o,
    output logic                  bist_o,
    output logic                  csn_t_o,
    output logic                  wen_t_o,
    output logic [ADDR_WIDTH-1:0] a_t_o,
    output logic [DATA_WIDTH-1:0] d_t_o,
    input  logic [DATA_WIDTH-1:0] q_t_i
);

    // Top half of the address space and the all-ones low address are never
    // exercised, so the sweep covers 0..N-1 with N = 2^(ADDR_WIDTH-1)-1.
    localparam int unsigned           NUM_ADDR  = (1 << (ADDR_WIDTH - 1)) - 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_ADDR - 1);

    logic [2:0]            state;
    logic [2:0]            state_next;
    logic [2:0]            elem;
    logic [2:0]            next_elem;
    logic                  op_idx;
    logic [1:0]            cur_op;
    logic                  op_last;
    logic                  elem_done;
    logic                  run_end;
    logic                  start_accept;

    logic                  addr_load;
    logic [ADDR_WIDTH-1:0] addr_load_val;
    logic                  addr_step;
    logic                  addr_up;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  addr_last;

    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] exp_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [2:0]            rd_elem_q;
    logic                  mismatch;

    regfile_bist_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MAX_ADDR   (LAST_ADDR)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (addr_load),
        .load_val (addr_load_val),
        .step     (addr_step),
        .up       (addr_up),
        .addr     (addr),
        .last     (addr_last)
    );

    // Decode the current op and the element/run boundaries it implies
    always_comb begin
        cur_op        = elem_op(elem, op_idx);
        op_last       = op_idx || (elem_op_count(elem) == 2'd1);
        elem_done     = op_last && addr_last;
        next_elem     = elem + 3'd1;
        run_end       = (state == ST_RUN) && elem_done && (elem == M5);
        start_accept  = (state == ST_IDLE) && start_i && !abort_i;
        addr_up       = elem_dir_up(elem);
        addr_load     = (state == ST_SETTLE) ||
                        ((state == ST_RUN) && elem_done && (elem != M5));
        addr_load_val = ((state == ST_RUN) && !elem_dir_up(next_elem)) ? LAST_ADDR : '0;
        addr_step     = (state == ST_RUN) && op_last && !addr_last;
        mismatch      = rd_valid_q && (q_t_i != exp_q);
    end

    // Next-state logic; abort wins over every non-idle transition
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   state_next = start_accept ? ST_SETTLE : ST_IDLE;
            ST_SETTLE: state_next = abort_i ? ST_IDLE : ST_RUN;
            ST_RUN:    state_next = abort_i ? ST_IDLE : (run_end ? ST_DRAIN : ST_RUN);
            ST_DRAIN:  state_next = abort_i ? ST_IDLE : ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // March position: element and op-within-element, cleared outside RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem   <= M0;
            op_idx <= 1'b0;
        end else if ((state != ST_RUN) || abort_i) begin
            elem   <= M0;
            op_idx <= 1'b0;
        end else if (op_last) begin
            op_idx <= 1'b0;
            if (elem_done && (elem != M5)) begin
                elem <= next_elem;
            end
        end else begin
            op_idx <= 1'b1;
        end
    end

    // Register the expectation of each read so it lines up with q_t_i next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            exp_q      <= '0;
            rd_addr_q  <= '0;
            rd_elem_q  <= 3'd0;
        end else begin
            rd_valid_q <= (state == ST_RUN) && cur_op[1] && !abort_i;
            exp_q      <= {DATA_WIDTH{cur_op[0]}};
            rd_addr_q  <= addr;
            rd_elem_q  <= elem;
        end
    end

    // Sticky failure capture: first mismatch only, cleared on start acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_o      <= 1'b0;
            fail_addr_o <= '0;
            fail_elem_o <= 3'd0;
        end else if (start_accept) begin
            fail_o      <= 1'b0;
            fail_addr_o <= '0;
            fail_elem_o <= 3'd0;
        end else if (mismatch && !fail_o) begin
            fail_o      <= 1'b1;
            fail_addr_o <= rd_addr_q;
            fail_elem_o <= rd_elem_q;
        end
    end

    // Pass verdict is formed on entry to DONE, folding in the final M5 check
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_o <= 1'b0;
        end else if (start_accept) begin
            pass_o <= 1'b0;
        end else if ((state == ST_DRAIN) && !abort_i) begin
            pass_o <= !(fail_o || mismatch);
        end
    end

    // Test-port drive: only RUN issues ops, every other state parks the port
    always_comb begin
        busy_o  = (state != ST_IDLE);
        bist_o  = busy_o;
        done_o  = (state == ST_DONE);
        csn_t_o = 1'b1;
        wen_t_o = 1'b1;
        a_t_o   = '0;
        d_t_o   = '0;
        if (state == ST_RUN) begin
            csn_t_o = 1'b0;
            a_t_o   = addr;
            if (!cur_op[1]) begin
                wen_t_o = 1'b0;
                d_t_o   = {DATA_WIDTH{cur_op[0]}};
            end
        end
    end

endmodule

// File: tb/tb_regfile_march_bist_ctrl.sv
// Directed bench for the March C- BIST controller, driving a behavioural
// register file with optional stuck-at fault injection.
module tb_regfile_march_bist_ctrl;

    localparam int AW = 5;
    localparam int DW = 32;
    // N = 15 writable addresses; 10*N ops; done in cycle 10*N+3 = 153,
    // i.e. 152 edges after the start-sampling edge.
    localparam int DONE_EDGES = 152;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i;
    logic          abort_i;
    logic          busy_o;
    logic          done_o;
    logic          pass_o;
    logic          fail_o;
    logic [AW-1:0] fail_addr_o;
    logic [2:0]    fail_elem_o;
    logic          bist_o;
    logic          csn_t_o;
    logic          wen_t_o;
    logic [AW-1:0] a_t_o;
    logic [DW-1:0] d_t_o;
    logic [DW-1:0] q_t_i;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int t0 = 0;

    // Register-file model state and protocol monitor counters
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] fault_addr = '0;
    logic [DW-1:0] sa1_mask = '0;
    logic [DW-1:0] sa0_mask = '0;
    int op_cnt = 0;
    int wr_cnt = 0;
    int bad_addr_cnt = 0;
    int bad_d_cnt = 0;

    regfile_march_bist_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .pass_o      (pass_o),
        .fail_o      (fail_o),
        .fail_addr_o (fail_addr_o),
        .fail_elem_o (fail_elem_o),
        .bist_o      (bist_o),
        .csn_t_o     (csn_t_o),
        .wen_t_o     (wen_t_o),
        .a_t_o       (a_t_o),
        .d_t_o       (d_t_o),
        .q_t_i       (q_t_i)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Free-running edge counter
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural register file with stuck-at faults applied on read, plus monitor
    always @(posedge clk) begin
        if (!csn_t_o) begin
            op_cnt++;
            if (a_t_o[AW-1] || (a_t_o[AW-2:0] == '1)) bad_addr_cnt++;
            if (wen_t_o) begin
                if (d_t_o != '0) bad_d_cnt++;
                if (a_t_o == fault_addr)
                    q_t_i <= (mem[a_t_o] | sa1_mask) & ~sa0_mask;
                else
                    q_t_i <= mem[a_t_o];
            end else begin
                wr_cnt++;
                mem[a_t_o] <= d_t_o;
            end
        end
    end

    // Count one comparison and report it if observed differs from expected
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic abort);
        start_i = start;
        abort_i = abort;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge; t0 records the edge that samples it
    task automatic startPulse();
        applyStimulus(1'b1, 1'b0);
        tick();
        t0 = cyc;
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic waitDone(input int budget, output int lat, output bit seen);
        seen = 1'b0;
        lat  = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done_o) begin
                seen = 1'b1;
                lat  = cyc - t0;
            end
        end
    endtask

    task automatic setFault(input logic [AW-1:0] addr, input logic [DW-1:0] s1, input logic [DW-1:0] s0);
        fault_addr = addr;
        sa1_mask   = s1;
        sa0_mask   = s0;
    endtask

    initial begin
        int  lat;
        bit  seen;
        int  base_ops;
        int  base_wr;
        int  dones;
        int  idle_cnt;
        int  first_done;

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0);
        #2;
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_bist", bist_o, 0);
        checkOutput("rst_csn", csn_t_o, 1);
        checkOutput("rst_wen", wen_t_o, 1);
        checkOutput("rst_done", done_o, 0);
        checkOutput("rst_pass_fail", {pass_o, fail_o}, 0);
        checkOutput("rst_a_d", {a_t_o, d_t_o}, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Start and abort together in IDLE: nothing happens
        applyStimulus(1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0);
        checkOutput("start_abort_idle", busy_o, 0);

        // Fault-free run
        $display("[TB] fault-free run");
        base_ops = op_cnt;
        base_wr  = wr_cnt;
        startPulse();
        checkOutput("run1_busy", {busy_o, bist_o}, 2'b11);
        waitDone(400, lat, seen);
        checkOutput("run1_done_seen", seen, 1);
        checkOutput("run1_done_lat", lat, DONE_EDGES);
        checkOutput("run1_pass", pass_o, 1);
        checkOutput("run1_fail", fail_o, 0);
        checkOutput("run1_ops", op_cnt - base_ops, 150);
        checkOutput("run1_writes", wr_cnt - base_wr, 75);
        checkOutput("run1_bad_addr", bad_addr_cnt, 0);
        checkOutput("run1_read_d", bad_d_cnt, 0);
        tick();
        checkOutput("run1_done_pulse", {done_o, busy_o}, 0);
        checkOutput("run1_pass_hold", {pass_o, fail_o}, 2'b10);

        // Stuck-at-1 bit 3 at address 5: first seen by M1 r0
        $display("[TB] stuck-at-1 run");
        setFault(5'd5, 32'h8, 32'h0);
        startPulse();
        checkOutput("sa1_cleared", {pass_o, fail_o}, 0);
        waitDone(400, lat, seen);
        checkOutput("sa1_done_lat", lat, DONE_EDGES);
        checkOutput("sa1_flags", {pass_o, fail_o}, 2'b01);
        checkOutput("sa1_addr", fail_addr_o, 5);
        checkOutput("sa1_elem", fail_elem_o, 1);
        tick();

        // Stuck-at-0 bit 0 at address 14: first seen by M2 r1
        $display("[TB] stuck-at-0 run");
        setFault(5'd14, 32'h0, 32'h1);
        startPulse();
        waitDone(400, lat, seen);
        checkOutput("sa0_done_seen", seen, 1);
        checkOutput("sa0_flags", {pass_o, fail_o}, 2'b01);
        checkOutput("sa0_addr", fail_addr_o, 14);
        checkOutput("sa0_elem", fail_elem_o, 2);
        tick();
        setFault('0, '0, '0);

        // Abort in cycle 40
        $display("[TB] abort run");
        startPulse();
        repeat (39) tick();
        checkOutput("abort_pre_busy", busy_o, 1);
        applyStimulus(1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0);
        checkOutput("abort_idle", {busy_o, bist_o, csn_t_o}, 3'b001);
        dones = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (done_o) dones++;
        end
        checkOutput("abort_no_done", dones, 0);
        checkOutput("abort_pass", {pass_o, fail_o}, 0);

        // Abort in the same cycle as the M1 mismatch at address 5 (cycle 28)
        $display("[TB] abort with mismatch");
        setFault(5'd5, 32'h8, 32'h0);
        startPulse();
        repeat (27) tick();
        applyStimulus(1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0);
        checkOutput("abmm_idle", busy_o, 0);
        checkOutput("abmm_flags", {pass_o, fail_o}, 2'b01);
        checkOutput("abmm_capture", {fail_addr_o, fail_elem_o}, {5'd5, 3'd1});
        setFault('0, '0, '0);
        tick();

        // Asynchronous reset in cycle 70 mid-RUN, then a clean run
        $display("[TB] mid-run reset");
        startPulse();
        repeat (69) tick();
        checkOutput("mrst_pre_busy", busy_o, 1);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("mrst_state", {busy_o, bist_o, csn_t_o, wen_t_o}, 4'b0011);
        checkOutput("mrst_a", a_t_o, 0);
        tick();
        rst_n = 1'b1;
        tick();
        startPulse();
        waitDone(400, lat, seen);
        checkOutput("mrst_rerun_lat", lat, DONE_EDGES);
        checkOutput("mrst_rerun_pass", {pass_o, fail_o}, 2'b10);
        tick();

        // Start held high: back-to-back runs with one IDLE cycle between
        $display("[TB] start held high");
        applyStimulus(1'b1, 1'b0);
        tick();
        t0 = cyc;
        waitDone(400, lat, seen);
        checkOutput("hold_first_lat", lat, DONE_EDGES);
        first_done = cyc;
        idle_cnt = 0;
        seen = 1'b0;
        for (int i = 1; i < 400 && !seen; i++) begin
            if (i >= 20 && i <= 30) start_i = (i % 2 == 0);
            tick();
            if (!busy_o) idle_cnt++;
            if (done_o) seen = 1'b1;
        end
        checkOutput("hold_second_seen", seen, 1);
        checkOutput("hold_period", cyc - first_done, DONE_EDGES + 2);
        checkOutput("hold_idle_cycles", idle_cnt, 1);
        checkOutput("hold_pass", pass_o, 1);
        applyStimulus(1'b0, 1'b0);
        tick();
        tick();
        checkOutput("hold_stop", busy_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_march_bist_ctrl.md
REGFILE_MARCH_BIST_CTRL -- requirements
Module: regfile_march_bist_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 5, meaning the register-file test-port address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the test-port data width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port start_i, input, 1 bit: request to run the test; sampled only in IDLE.
REQ-006 The block SHALL have port abort_i, input, 1 bit: cancel a running test.
REQ-007 The block SHALL have port busy_o, output, 1 bit: high in every state except IDLE.
REQ-008 The block SHALL have port done_o, output, 1 bit: one-cycle completion pulse.
REQ-009 The block SHALL have ports pass_o and fail_o, outputs, 1 bit each: sticky results.
REQ-010 The block SHALL have port fail_addr_o, output, ADDR_WIDTH bits: A_T value of the first mismatch.
REQ-011 The block SHALL have port fail_elem_o, output, 3 bits: march element index (0-5) of the first mismatch.
REQ-012 The block SHALL have ports bist_o, csn_t_o and wen_t_o, outputs, 1 bit each: BIST enable, chip select (active-low) and write enable (low = write, high = read).
REQ-013 The block SHALL have port a_t_o, output, ADDR_WIDTH bits: test address.
REQ-014 The block SHALL have port d_t_o, output, DATA_WIDTH bits: test write data.
REQ-015 The block SHALL have port q_t_i, input, DATA_WIDTH bits: test read data, valid in the cycle after a read is issued.

Function
REQ-016 The FSM SHALL have states IDLE, SETTLE, RUN, DRAIN and DONE; IDLE->SETTLE when start_i=1; SETTLE->RUN after 1 cycle; RUN->DRAIN after the last op; DRAIN->DONE after 1 cycle; DONE->IDLE after 1 cycle.
REQ-017 The test address range SHALL be A_T = 0..N-1, with N = 2^(ADDR_WIDTH-1)-1 (15 at default); a_t_o MSB SHALL always be 0, and the all-ones low-bit address (it maps to unwritable register 0) SHALL never be issued.
REQ-018 The test SHALL be March C-, with D0 = all zeros and D1 = all ones: M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0); M5 down(r0). "up" means address 0->N-1 and "down" means N-1->0.
REQ-019 RUN SHALL issue exactly one op per cycle with no bubbles, 10*N ops in total.
REQ-020 A write op SHALL drive csn_t_o=0, wen_t_o=0, d_t_o=pattern.
REQ-021 A read op SHALL drive csn_t_o=0 and wen_t_o=1; d_t_o SHALL be 0 during a read op.
REQ-022 The expected value and a valid flag for each read SHALL be registered, and q_t_i SHALL be compared against them in the following cycle; this includes the DRAIN cycle, which compares the final M5 read.
REQ-023 In IDLE, SETTLE, DRAIN and DONE the block SHALL drive csn_t_o=1, wen_t_o=1, a_t_o=0 and d_t_o=0.
REQ-024 bist_o SHALL be high exactly while busy_o is high.
REQ-025 With start_i sampled at edge t0, done_o SHALL be high in cycle 10*N+3 after t0 (cycle 153 at default).
REQ-026 On start acceptance, pass_o, fail_o, fail_addr_o and fail_elem_o SHALL clear.
REQ-027 The first mismatch SHALL set fail_o and capture fail_addr_o and fail_elem_o; later mismatches SHALL not overwrite the capture, and the test SHALL continue to completion.
REQ-028 In DONE, pass_o SHALL be set to the inverse of fail_o; pass_o and fail_o SHALL hold until the next start.
REQ-029 start_i SHALL be ignored when busy_o=1.
REQ-030 A start_i held high through DONE SHALL restart the test only after one cycle in IDLE.
REQ-031 abort_i=1 in any non-IDLE state SHALL force IDLE at the next edge, with no done_o and pass_o=0; fail_o and its captured data SHALL be retained.
REQ-032 abort_i and start_i both high in IDLE SHALL leave the block in IDLE.
REQ-033 A mismatch in the same cycle as abort_i SHALL still be captured.

Reset
REQ-034 rst_n low SHALL immediately force IDLE, bist_o=0, csn_t_o=1, wen_t_o=1, and all other outputs to 0, including mid-test.
REQ-035 All internal counters and pipeline flags SHALL reset to 0.

Structure
REQ-036 Package regfile_bist_pkg SHALL hold the FSM state enum, the march element enum (M0-M5), the per-element op-count, direction and pattern constants, and the op encoding.
REQ-037 One sub-module SHALL be used: regfile_bist_addr_gen, an up/down address counter with load and last-address flag.
REQ-038 The controller SHALL connect directly to the BIST/CSN_T/WEN_T/A_T/D_T/Q_T ports of the register-file test wrapper; DIFT tag test ports are out of scope and are tied off by the integrator.

Verification
REQ-039 Scenario: fault-free behavioural register file, start pulse -> done_o in cycle 153, pass_o=1, fail_o=0, no issued A_T equals 15 or has MSB set.
REQ-040 Scenario: stuck-at-1 on bit 3 at A_T=5 -> fail_o=1, fail_addr_o=5, fail_elem_o=1, done_o still in cycle 153.
REQ-041 Scenario: stuck-at-0 on bit 0 at A_T=14 -> fail_addr_o=14, fail_elem_o=2.
REQ-042 Scenario: abort_i pulsed in cycle 40 -> IDLE in cycle 41, bist_o=0, done_o never asserts, pass_o=0.
REQ-043 Scenario: rst_n asserted in cycle 70 mid-RUN -> outputs reach reset values asynchronously; a following start completes a full run and passes.
REQ-044 Scenario: start_i held high continuously -> back-to-back runs separated by exactly one IDLE cycle; start_i toggled during RUN has no effect.
